btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; successor to the single-button debouncer.
- Per channel: 2-flop synchroniser, tick-sampled shift-register filter with hysteresis, press/release one-clock pulses, long-press detect and auto-repeat.
- Everything runs on `clk`. The sample rate comes from a shared single-cycle tick enable, not a derived clock.
- Sits between raw board buttons and FSM/control logic (e.g. sensor trigger, mode select).

Parameters:
- N_CH, 4: number of independent button channels.
- CLK_DIV, 100000: clk cycles per sample tick (100 MHz -> 1 kHz); must be >= 2.
- DEPTH, 8: shift-register length (consecutive equal samples needed to change level); must be >= 2.
- LONG_TICKS, 1000: ticks of continuous hold, counted from press, before o_long fires; must be >= 1.
- REPEAT_TICKS, 200: tick period of o_repeat after o_long; 0 disables repeat.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- i_btn, input, N_CH: raw asynchronous button inputs, 1 = pressed.
- o_level, output, N_CH: debounced level per channel.
- o_press, output, N_CH: 1-clk pulse on debounced rising edge.
- o_release, output, N_CH: 1-clk pulse on debounced falling edge.
- o_long, output, N_CH: 1-clk pulse when hold reaches LONG_TICKS.
- o_repeat, output, N_CH: 1-clk pulse every REPEAT_TICKS ticks after o_long while still held.

Behaviour:
- Reset (rst=0, async): tick counter, tick, synchronisers, shift registers, hold counters, FSMs and all outputs go to 0. Release of reset restarts the tick counter from 0.
- Tick generator:
  - Counter 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - Registered tick=1 for exactly one clk when the counter wraps, i.e. every CLK_DIV clks.
- Synchroniser: 2 flops per channel, so sync = i_btn delayed 2 clks.
- Shift register (DEPTH bits/channel): on tick cycles only, sr <= {sync, sr[DEPTH-1:1]}; otherwise it holds.
- Level with hysteresis (evaluated every clk, registered):
  - &sr -> level <= 1.
  - ~|sr -> level <= 0.
  - Mixed contents -> hold. A bouncing input never toggles o_level.
- Edge pulses:
  - o_press is registered and high in the first cycle o_level reads 1.
  - o_release is high in the first cycle o_level reads 0.
  - Neither is ever high for 2 consecutive clks.
- Per-channel FSM, hold counter cnt sized to max(LONG_TICKS, REPEAT_TICKS):
  - IDLE: on level rise -> HELD, cnt=0.
  - HELD: each tick cnt++. On the tick where cnt+1 == LONG_TICKS: o_long=1, cnt=0, go to REPEAT (REPEAT_TICKS>0) or LONGHOLD (REPEAT_TICKS=0).
  - REPEAT: each tick cnt++. On cnt+1 == REPEAT_TICKS: o_repeat=1, cnt=0, stay in REPEAT.
  - LONGHOLD: idle until release; cnt frozen.
  - Any state, level fall -> IDLE, cnt=0.
- Simultaneous events:
  - If the level fall and a long/repeat condition occur in the same cycle, release wins and o_long/o_repeat are suppressed.
  - o_press and o_long can never coincide (LONG_TICKS >= 1).
- Latency, input steady from before a tick boundary:
  - The rising o_level asserts 1 clk after the DEPTH-th tick that samples sync=1.
  - Worst case after the i_btn edge: 2 + DEPTH*CLK_DIV + 1 clks.
- Channels are fully independent; multiple channels may pulse in the same cycle.
- Reset mid-hold: all state clears; no release pulse is emitted. After reset, a held button produces a fresh o_press once DEPTH ones are sampled.

Test Plan (N_CH=2, CLK_DIV=4, DEPTH=4, LONG_TICKS=10, REPEAT_TICKS=3):
- Clean press: ch0 high and steady -> o_level[0] rises 1 clk after the 4th tick sampling 1, with o_press[0] high for exactly 1 clk; ch1 stays 0 throughout.
- Bounce: ch0 toggles every 3 clks for 40 clks then stays high -> no o_press during the toggling; exactly one o_press after 4 consecutive 1-samples. The same toggling while o_level=1 -> no o_release.
- Long + repeat: hold ch0 for 30 ticks -> o_long 10 ticks after o_press, then o_repeat at +3, +6, +9 … ticks; release -> one o_release, pulses stop, and no o_repeat in the release cycle.
- REPEAT_TICKS=0 variant: hold 30 ticks -> exactly one o_long, zero o_repeat.
- Two channels: ch0 and ch1 pressed on the same clk -> o_press[1:0]=2'b11 in the same cycle; ch1 released early -> ch0 long/repeat timing unaffected.
- Async reset: assert rst=0 mid-REPEAT, asynchronously to clk -> all outputs 0 immediately; release rst with the button still held -> new o_press after 4 ticks; no o_release emitted.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// ---------------------------------------------------------------------------
// btn_debounce_multi
//   Multi-channel push-button conditioner. A single shared tick enable sets
//   the sample rate; each channel owns a 2-flop synchroniser, a tick-sampled
//   shift-register filter with hysteresis, press/release pulses and a
//   long-press / auto-repeat FSM.
//
// Ports
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   i_btn     : [N_CH] raw button inputs, 1 = pressed
//   o_level   : [N_CH] debounced level
//   o_press   : [N_CH] 1-clk pulse on debounced rising edge
//   o_release : [N_CH] 1-clk pulse on debounced falling edge
//   o_long    : [N_CH] 1-clk pulse when the hold reaches LONG_TICKS
//   o_repeat  : [N_CH] 1-clk pulse every REPEAT_TICKS ticks after o_long
// ---------------------------------------------------------------------------

// Per-channel conditioner. Ports as the top, one bit wide, plus i_tick.
module btn_debounce_ch #(
    parameter int DEPTH        = 8,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);
    localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_RPT, S_LHOLD} state_t;

    logic [1:0]       sync_q;
    logic [DEPTH-1:0] sr;
    logic             level_q;
    logic             rise_ev, fall_ev;
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             long_nxt, rep_nxt;

    // Synchroniser and tick-sampled filter; newest sample enters at the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            sr     <= '0;
        end else begin
            sync_q <= {sync_q[0], i_btn};
            if (i_tick) sr <= {sync_q[1], sr[DEPTH-1:1]};
        end
    end

    // Hysteresis: only a full window of equal samples moves the level, so
    // these events are also the exact cycles the level flips.
    assign rise_ev = (&sr)  & ~level_q;
    assign fall_ev = (~|sr) &  level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            if (rise_ev) level_q <= 1'b1;
            else if (fall_ev) level_q <= 1'b0;
            o_press   <= rise_ev;
            o_release <= fall_ev;
        end
    end

    assign o_level = level_q;

    // FSM state register (pulse outputs registered alongside)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_long   <= long_nxt;
            o_repeat <= rep_nxt;
        end
    end

    // FSM next state; a falling level overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (fall_ev) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: if (rise_ev) begin
                    state_nxt = S_HELD;
                    cnt_nxt   = '0;
                end
                S_HELD: if (i_tick) begin
                    if (cnt == LONG_LAST) begin
                        state_nxt = (REPEAT_TICKS > 0) ? S_RPT : S_LHOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                S_RPT: if (i_tick) begin
                    cnt_nxt = (cnt == REP_LAST) ? '0 : cnt + CW'(1);
                end
                default: ;  // S_LHOLD: wait for release, counter frozen
            endcase
        end
    end

    // FSM outputs; suppressed when the release lands in the same cycle.
    always_comb begin
        long_nxt = ~fall_ev & (state == S_HELD) & i_tick & (cnt == LONG_LAST);
        rep_nxt  = ~fall_ev & (state == S_RPT)  & i_tick & (cnt == REP_LAST);
    end
endmodule

module btn_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int CLK_DIV      = 100000,
    parameter int DEPTH        = 8,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TLAST = TW'(CLK_DIV - 1);

    logic [TW-1:0] tcnt;
    logic          tick;

    // Shared sample tick: one registered pulse every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TLAST);
            tcnt <= (tcnt == TLAST) ? '0 : tcnt + TW'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .DEPTH        (DEPTH),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (tick),
            .i_btn     (i_btn[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g]),
            .o_repeat  (o_repeat[g])
        );
    end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: two instances (repeat period 3 and repeat
// disabled) share the same button stimulus. A tick/sample-level model
// predicts every output each clock.
module tb_btn_debounce_multi;
    localparam int N_CH = 2;
    localparam int CDIV = 4;
    localparam int DEP  = 4;
    localparam int LONG = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CH-1:0]           i_btn;
    logic [1:0][N_CH-1:0]      o_lvl, o_prs, o_rel, o_lng, o_rep;

    always #5 clk = ~clk;

    btn_debounce_multi #(.N_CH(N_CH), .CLK_DIV(CDIV), .DEPTH(DEP),
                         .LONG_TICKS(LONG), .REPEAT_TICKS(3)) u_dut (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(o_lvl[0]), .o_press(o_prs[0]), .o_release(o_rel[0]),
        .o_long(o_lng[0]), .o_repeat(o_rep[0]));

    btn_debounce_multi #(.N_CH(N_CH), .CLK_DIV(CDIV), .DEPTH(DEP),
                         .LONG_TICKS(LONG), .REPEAT_TICKS(0)) u_dut_r0 (
        .clk(clk), .rst(rst), .i_btn(i_btn),
        .o_level(o_lvl[1]), .o_press(o_prs[1]), .o_release(o_rel[1]),
        .o_long(o_lng[1]), .o_repeat(o_rep[1]));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              n;                       // clocks since reset release
    logic [N_CH-1:0] hist[$];                 // last few i_btn values
    bit              m_lvl[2][N_CH];
    bit              m_pp[2][N_CH], m_pr[2][N_CH];
    int              m_hold[2][N_CH], m_ones[2][N_CH], m_zeros[2][N_CH];
    logic [N_CH-1:0] e_lvl[2], e_prs[2], e_rel[2], e_lng[2], e_rep[2];
    int              tot_prs[2][N_CH], tot_rel[2][N_CH], tot_lng[2][N_CH], tot_rep[2][N_CH];
    int              both_prs = 0;
    int              cyc = 0;

    function automatic int rep_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    task automatic model_edge();
        logic [N_CH-1:0] smp;
        bit tick_edge;
        if (!rst) begin
            n = 0;
            hist.delete();
            for (int d = 0; d < 2; d++) begin
                e_lvl[d] = '0; e_prs[d] = '0; e_rel[d] = '0; e_lng[d] = '0; e_rep[d] = '0;
                for (int c = 0; c < N_CH; c++) begin
                    m_lvl[d][c] = 0; m_pp[d][c] = 0; m_pr[d][c] = 0;
                    m_hold[d][c] = 0; m_ones[d][c] = 0; m_zeros[d][c] = 0;
                end
            end
            return;
        end
        n++;
        hist.push_back(i_btn);
        if (hist.size() > 3) void'(hist.pop_front());
        // Samples are taken every CDIV clocks, first at clock CDIV+1, and
        // see the button as it was two clocks earlier.
        tick_edge = (n > CDIV) && ((n - 1) % CDIV == 0);
        smp = hist[0];
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N_CH; c++) begin
                e_lvl[d][c] = m_lvl[d][c];
                e_prs[d][c] = m_pp[d][c];
                e_rel[d][c] = m_pr[d][c];
                e_lng[d][c] = 1'b0;
                e_rep[d][c] = 1'b0;
                m_pp[d][c] = 0;
                m_pr[d][c] = 0;
                if (tick_edge) begin
                    if (m_lvl[d][c]) begin
                        m_hold[d][c]++;
                        if (m_hold[d][c] == LONG) e_lng[d][c] = 1'b1;
                        else if (rep_of(d) > 0 && m_hold[d][c] > LONG &&
                                 (m_hold[d][c] - LONG) % rep_of(d) == 0) e_rep[d][c] = 1'b1;
                    end
                    if (smp[c]) begin m_ones[d][c]++; m_zeros[d][c] = 0; end
                    else        begin m_zeros[d][c]++; m_ones[d][c] = 0; end
                    if (!m_lvl[d][c] && m_ones[d][c] >= DEP) begin
                        m_lvl[d][c] = 1; m_hold[d][c] = 0; m_pp[d][c] = 1;
                    end else if (m_lvl[d][c] && m_zeros[d][c] >= DEP) begin
                        m_lvl[d][c] = 0; m_pr[d][c] = 1;
                    end
                end
            end
        end
    endtask

    // One clock: advance the model, then compare every output 1 time unit
    // after the edge. Returns at posedge+1, where the caller drives inputs.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_level@%0d", d, cyc),   o_lvl[d], e_lvl[d]);
            chk($sformatf("d%0d_press@%0d", d, cyc),   o_prs[d], e_prs[d]);
            chk($sformatf("d%0d_release@%0d", d, cyc), o_rel[d], e_rel[d]);
            chk($sformatf("d%0d_long@%0d", d, cyc),    o_lng[d], e_lng[d]);
            chk($sformatf("d%0d_repeat@%0d", d, cyc),  o_rep[d], e_rep[d]);
            for (int c = 0; c < N_CH; c++) begin
                tot_prs[d][c] += int'(o_prs[d][c]);
                tot_rel[d][c] += int'(o_rel[d][c]);
                tot_lng[d][c] += int'(o_lng[d][c]);
                tot_rep[d][c] += int'(o_rep[d][c]);
            end
        end
        if (o_prs[0] == 2'b11) both_prs++;
    endtask

    initial begin
        int p0, r0, l0, l1, q1, b0;
        int run_left[N_CH];
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N_CH; c++) begin
                tot_prs[d][c] = 0; tot_rel[d][c] = 0; tot_lng[d][c] = 0; tot_rep[d][c] = 0;
            end
        rst   = 1'b0;
        i_btn = '0;
        repeat (3) step();
        #3 rst = 1'b1;
        repeat (8) step();

        // clean press on ch0
        p0 = tot_prs[0][0];
        i_btn = 2'b01;
        repeat (40) step();
        chk("clean_press_cnt", tot_prs[0][0] - p0, 1);
        chk("clean_ch1_press", tot_prs[0][1], 0);
        i_btn = 2'b00;
        repeat (40) step();

        // bounce from released: no press until steady
        p0 = tot_prs[0][0];
        for (int k = 0; k < 40; k++) begin
            i_btn[0] = ((k / 3) % 2 == 0);
            step();
        end
        chk("bounce_no_press", tot_prs[0][0] - p0, 0);
        i_btn[0] = 1'b1;
        repeat (40) step();
        chk("bounce_one_press", tot_prs[0][0] - p0, 1);

        // bounce while pressed: no release
        r0 = tot_rel[0][0];
        for (int k = 0; k < 40; k++) begin
            i_btn[0] = ((k / 3) % 2 == 0);
            step();
        end
        i_btn[0] = 1'b1;
        repeat (20) step();
        chk("bounce_no_release", tot_rel[0][0] - r0, 0);
        i_btn = 2'b00;
        repeat (40) step();

        // long + repeat, and repeat-disabled variant, 30 ticks held
        l0 = tot_lng[0][0]; l1 = tot_lng[1][0]; q1 = tot_rep[1][0]; r0 = tot_rel[0][0];
        i_btn = 2'b01;
        repeat (30 * CDIV) step();
        i_btn = 2'b00;
        repeat (40) step();
        chk("long_cnt", tot_lng[0][0] - l0, 1);
        chk("r0_long_cnt", tot_lng[1][0] - l1, 1);
        chk("r0_repeat_cnt", tot_rep[1][0] - q1, 0);
        chk("long_release_cnt", tot_rel[0][0] - r0, 1);

        // two channels pressed on the same clock, ch1 released early
        b0 = both_prs;
        i_btn = 2'b11;
        repeat (20 * CDIV) step();
        i_btn = 2'b01;
        repeat (20 * CDIV) step();
        chk("dual_press_same_cycle", both_prs - b0, 1);
        i_btn = 2'b00;
        repeat (40) step();

        // async reset in the middle of the repeat phase
        i_btn = 2'b11;
        repeat (100) step();
        r0 = tot_rel[0][0];
        p0 = tot_prs[0][0];
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst_level_d%0d", d),   o_lvl[d], '0);
            chk($sformatf("arst_press_d%0d", d),   o_prs[d], '0);
            chk($sformatf("arst_release_d%0d", d), o_rel[d], '0);
            chk($sformatf("arst_long_d%0d", d),    o_lng[d], '0);
            chk($sformatf("arst_repeat_d%0d", d),  o_rep[d], '0);
        end
        repeat (3) step();
        #3 rst = 1'b1;
        repeat (40) step();
        chk("arst_no_release", tot_rel[0][0] - r0, 0);
        chk("arst_fresh_press", tot_prs[0][0] - p0, 1);
        i_btn = 2'b00;
        repeat (40) step();

        // random runs: short glitches mixed with long holds
        for (int c = 0; c < N_CH; c++) run_left[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (run_left[c] == 0) begin
                    i_btn[c] = 1'($urandom_range(0, 1));
                    run_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                              : int'($urandom_range(10, 180));
                end
                run_left[c]--;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
